// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between an operand producer, alu_pipe and a result consumer.
// The master side drives operands and out_ready; the slave side (the ALU) drives results.
interface alu_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a0_mux;
    logic [WIDTH-1:0] a1_mux;
    logic             a_sel;
    logic [WIDTH-1:0] b;
    logic [2:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, a0_mux, a1_mux, a_sel, b, ctrl, out_ready,
        input  in_ready, out_valid, out, flag_z, flag_n, flag_c, flag_v
    );

    modport slave (
        input  in_valid, a0_mux, a1_mux, a_sel, b, ctrl, out_ready,
        output in_ready, out_valid, out, flag_z, flag_n, flag_c, flag_v
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 captures the selected operands, S2 computes and registers
// the result with Z/N/C/V flags. Valid/ready on both sides, at most two operations buffered.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_pipe_if.slave bus
);
    localparam int           MSB     = WIDTH - 1;
    localparam logic [SHW:0] WIDTH_L = (SHW + 1)'(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_LSL = 3'd6;
    localparam logic [2:0] OP_LSR = 3'd7;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_ctrl_q, s1_ctrl_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [3:0]       flags_q, flags_d;
    logic             s2_adv_s;
    logic             s1_adv_s;
    logic [WIDTH+1:0] res_s;

    // Returns {result, carry, overflow}; shifts read their amount from b[SHW-1:0].
    function automatic logic [WIDTH+1:0] alu_f(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] bb,
                                                input logic [2:0]       op);
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        logic [SHW-1:0]   s;
        logic [SHW:0]     s_w;
        ext = {(WIDTH + 1){1'b0}};
        r   = {WIDTH{1'b0}};
        c   = 1'b0;
        v   = 1'b0;
        s   = bb[SHW-1:0];
        s_w = {1'b0, s};
        case (op)
            OP_ADD: begin
                ext = {1'b0, a} + {1'b0, bb};
                r   = ext[MSB:0];
                c   = ext[WIDTH];
                v   = (a[MSB] == bb[MSB]) && (r[MSB] != a[MSB]);
            end
            OP_SUB: begin
                ext = {1'b0, a} - {1'b0, bb};
                r   = ext[MSB:0];
                c   = ext[WIDTH];
                v   = (a[MSB] != bb[MSB]) && (r[MSB] != a[MSB]);
            end
            OP_OR:  r = a | bb;
            OP_AND: r = a & bb;
            OP_XOR: r = a ^ bb;
            OP_NOT: r = ~a;
            // Bit WIDTH of the widened value is the last bit shifted out (0 when s = 0).
            OP_LSL: begin
                if (s_w >= WIDTH_L) begin
                    r = {WIDTH{1'b0}};
                    c = 1'b0;
                end else begin
                    ext = {1'b0, a} << s;
                    r   = ext[MSB:0];
                    c   = ext[WIDTH];
                end
            end
            OP_LSR: begin
                if (s_w >= WIDTH_L) begin
                    r = {WIDTH{1'b0}};
                    c = 1'b0;
                end else begin
                    ext = {a, 1'b0} >> s;
                    r   = ext[WIDTH:1];
                    c   = ext[0];
                end
            end
            default: r = {WIDTH{1'b0}};
        endcase
        return {r, c, v};
    endfunction

    // Pipeline advance: S2 frees when empty or drained, S1 when empty or S2 frees.
    always_comb begin
        s2_adv_s = !out_valid_q || bus.out_ready;
        s1_adv_s = !s1_valid_q || s2_adv_s;
    end

    // S1 next state: operands are captured only on an accepted transfer.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_ctrl_d  = s1_ctrl_q;
        if (s1_adv_s) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_a_d    = bus.a_sel ? bus.a1_mux : bus.a0_mux;
                s1_b_d    = bus.b;
                s1_ctrl_d = bus.ctrl;
            end else begin
                s1_a_d    = s1_a_q;
                s1_b_d    = s1_b_q;
                s1_ctrl_d = s1_ctrl_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2 next state: result and flags {z,n,c,v} load only behind a valid S1 entry.
    always_comb begin
        res_s       = alu_f(s1_a_q, s1_b_q, s1_ctrl_q);
        out_valid_d = out_valid_q;
        out_d       = out_q;
        flags_d     = flags_q;
        if (s2_adv_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d   = res_s[WIDTH+1:2];
                flags_d = {(res_s[WIDTH+1:2] == {WIDTH{1'b0}}), res_s[WIDTH+1],
                           res_s[1], res_s[0]};
            end else begin
                out_d   = out_q;
                flags_d = flags_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= {WIDTH{1'b0}};
            s1_b_q      <= {WIDTH{1'b0}};
            s1_ctrl_q   <= 3'd0;
            out_valid_q <= 1'b0;
            out_q       <= {WIDTH{1'b0}};
            flags_q     <= 4'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_ctrl_q   <= s1_ctrl_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.in_ready  = s1_adv_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.flag_z    = flags_q[3];
    assign bus.flag_n    = flags_q[2];
    assign bus.flag_c    = flags_q[1];
    assign bus.flag_v    = flags_q[0];
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: an 8-bit and a 12-bit instance, directed vectors with
// hand-computed results, backpressure, mid-stream reset and a randomised 12-bit run.
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(8))  bus8  ();
    alu_pipe_if #(.WIDTH(12)) bus12 ();

    alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    alu_pipe #(.WIDTH(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

    int          n_total = 0;
    int          n_pass  = 0;
    logic [11:0] exp8_q  [$];
    logic [15:0] exp12_q [$];
    logic [11:0] e8;
    logic [15:0] e12;
    logic        rand_phase = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Independent reference for the 12-bit instance: integer arithmetic and bit-serial shifts.
    function automatic logic [15:0] model12(logic [11:0] a, logic [11:0] bb, logic [2:0] op);
        int ai, bi, r, sa, sb, sr, s;
        logic c, v;
        ai = int'(a); bi = int'(bb);
        sa = a[11] ? ai - 4096 : ai;
        sb = bb[11] ? bi - 4096 : bi;
        c = 1'b0; v = 1'b0; r = 0;
        s = bi % 16;
        case (op)
            3'd0: begin r = ai + bi; c = (r > 4095); sr = sa + sb; v = (sr > 2047) || (sr < -2048); r = r % 4096; end
            3'd1: begin r = ai - bi; c = (ai < bi); sr = sa - sb; v = (sr > 2047) || (sr < -2048); r = (r + 4096) % 4096; end
            3'd2: r = int'(a | bb);
            3'd3: r = int'(a & bb);
            3'd4: r = int'(a ^ bb);
            3'd5: r = 4095 - ai;
            3'd6: begin
                r = ai;
                for (int k = 0; k < s; k++) begin c = ((r / 2048) % 2) == 1; r = (r * 2) % 4096; end
                if (s >= 12) begin r = 0; c = 1'b0; end
            end
            default: begin
                r = ai;
                for (int k = 0; k < s; k++) begin c = (r % 2) == 1; r = r / 2; end
                if (s >= 12) begin r = 0; c = 1'b0; end
            end
        endcase
        return {12'(r), (r == 0), (r >= 2048), c, v};
    endfunction

    // Monitor for the 8-bit instance: pop on transfer, compare against queue head while stalled.
    always @(negedge clk) begin
        if (rst_n && bus8.out_valid) begin
            if (exp8_q.size() == 0) begin
                n_total++;
                $display("FAIL out8_unexpected: got out=%0h with no result pending", bus8.out);
            end else if (bus8.out_ready) begin
                e8 = exp8_q.pop_front();
                chk("out8", 32'({bus8.out, bus8.flag_z, bus8.flag_n, bus8.flag_c, bus8.flag_v}), 32'(e8));
            end else begin
                chk("out8_stall", 32'({bus8.out, bus8.flag_z, bus8.flag_n, bus8.flag_c, bus8.flag_v}), 32'(exp8_q[0]));
            end
        end
    end

    // Monitor for the 12-bit instance.
    always @(negedge clk) begin
        if (rst_n && bus12.out_valid) begin
            if (exp12_q.size() == 0) begin
                n_total++;
                $display("FAIL out12_unexpected: got out=%0h with no result pending", bus12.out);
            end else if (bus12.out_ready) begin
                e12 = exp12_q.pop_front();
                chk("out12", 32'({bus12.out, bus12.flag_z, bus12.flag_n, bus12.flag_c, bus12.flag_v}), 32'(e12));
            end else begin
                chk("out12_stall", 32'({bus12.out, bus12.flag_z, bus12.flag_n, bus12.flag_c, bus12.flag_v}), 32'(exp12_q[0]));
            end
        end
    end

    // Random consumer backpressure on the 12-bit instance.
    always @(posedge clk) begin
        if (rand_phase) begin
            #1;
            bus12.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send8(logic [7:0] a0, logic [7:0] a1, logic sel, logic [7:0] bb, logic [2:0] op, logic [11:0] exp);
        int n = 0;
        bus8.in_valid = 1'b1; bus8.a0_mux = a0; bus8.a1_mux = a1;
        bus8.a_sel = sel; bus8.b = bb; bus8.ctrl = op;
        @(negedge clk);
        while (!bus8.in_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus8.in_ready) begin
            n_total++;
            $display("FAIL send8_timeout: in_ready stayed 0 for %0d cycles", n);
        end else begin
            exp8_q.push_back(exp);
        end
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic send12(logic [11:0] a0, logic [11:0] a1, logic sel, logic [11:0] bb, logic [2:0] op, logic [15:0] exp);
        int n = 0;
        bus12.in_valid = 1'b1; bus12.a0_mux = a0; bus12.a1_mux = a1;
        bus12.a_sel = sel; bus12.b = bb; bus12.ctrl = op;
        @(negedge clk);
        while (!bus12.in_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus12.in_ready) begin
            n_total++;
            $display("FAIL send12_timeout: in_ready stayed 0 for %0d cycles", n);
        end else begin
            exp12_q.push_back(exp);
        end
        @(posedge clk); #1;
        bus12.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp8_q.size() != 0 || exp12_q.size() != 0) && n < 300) begin @(posedge clk); n++; end
        @(posedge clk);
        chk("drain8_left", 32'(exp8_q.size()), 32'd0);
        chk("drain12_left", 32'(exp12_q.size()), 32'd0);
        #1;
    endtask

    // {a0, a1, a_sel, b, ctrl, expected {out, z, n, c, v}}
    logic [39:0] vec8 [15];
    logic [39:0] v8;
    logic [11:0] ra0, ra1, rb;
    logic        rs;
    logic [2:0]  rop;
    int          bp_n;

    initial begin
        vec8 = '{
            {8'hFF, 8'h00, 1'b0, 8'h01, 3'd0, 12'h00A},
            {8'h55, 8'h00, 1'b1, 8'h01, 3'd1, 12'hFF6},
            {8'h80, 8'h7F, 1'b0, 8'h01, 3'd1, 12'h7F1},
            {8'h80, 8'h80, 1'b0, 8'h80, 3'd0, 12'h00B},
            {8'h81, 8'h00, 1'b0, 8'h01, 3'd6, 12'h022},
            {8'h81, 8'h00, 1'b0, 8'h09, 3'd6, 12'h022},
            {8'h81, 8'h00, 1'b0, 8'h03, 3'd7, 12'h100},
            {8'h01, 8'hFF, 1'b0, 8'h01, 3'd7, 12'h00A},
            {8'hA5, 8'h00, 1'b0, 8'h00, 3'd6, 12'hA54},
            {8'h80, 8'h00, 1'b0, 8'h07, 3'd7, 12'h010},
            {8'h01, 8'h00, 1'b0, 8'h07, 3'd6, 12'h804},
            {8'h0F, 8'hF0, 1'b0, 8'h3C, 3'd2, 12'h3F0},
            {8'h0F, 8'hF0, 1'b1, 8'h3C, 3'd3, 12'h300},
            {8'h0F, 8'hF0, 1'b1, 8'h3C, 3'd4, 12'hCC4},
            {8'h0F, 8'hF0, 1'b0, 8'h3C, 3'd5, 12'hF04}
        };
        rst_n = 1'b0;
        bus8.in_valid = 1'b0;  bus8.out_ready = 1'b1;
        bus8.a0_mux = 8'h00;   bus8.a1_mux = 8'h00; bus8.a_sel = 1'b0; bus8.b = 8'h00; bus8.ctrl = 3'd0;
        bus12.in_valid = 1'b0; bus12.out_ready = 1'b1;
        bus12.a0_mux = 12'h000; bus12.a1_mux = 12'h000; bus12.a_sel = 1'b0; bus12.b = 12'h000; bus12.ctrl = 3'd0;

        #12;
        chk("rst_out_valid8", 32'(bus8.out_valid), 32'd0);
        chk("rst_out8", 32'({bus8.out, bus8.flag_z, bus8.flag_n, bus8.flag_c, bus8.flag_v}), 32'd0);
        chk("rst_in_ready8", 32'(bus8.in_ready), 32'd1);
        chk("rst_out_valid12", 32'(bus12.out_valid), 32'd0);
        chk("rst_in_ready12", 32'(bus12.in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty-pipe latency: accepted at edge k, visible after edge k+1.
        chk("lat_in_ready", 32'(bus8.in_ready), 32'd1);
        bus8.in_valid = 1'b1; bus8.a0_mux = 8'h7F; bus8.a1_mux = 8'h00;
        bus8.a_sel = 1'b0; bus8.b = 8'h01; bus8.ctrl = 3'd0;
        exp8_q.push_back(12'h805);
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        chk("lat_edge_k", 32'(bus8.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_edge_k1", 32'(bus8.out_valid), 32'd1);

        for (int i = 0; i < 15; i++) begin
            v8 = vec8[i];
            send8(v8[39:32], v8[31:24], v8[23], v8[22:15], v8[14:12], v8[11:0]);
        end

        // Input noise while in_valid is low must not produce results.
        for (int i = 0; i < 3; i++) begin
            bus8.a0_mux = 8'($urandom); bus8.b = 8'($urandom); bus8.ctrl = 3'($urandom);
            @(posedge clk); #1;
        end
        drain();

        // Backpressure: five back-to-back ADDs, consumer stalls 3 cycles after the first result.
        bp_n = 0;
        fork
            begin
                do begin @(posedge clk); #1; bp_n++; end while (!bus8.out_valid && bp_n < 50);
                if (!bus8.out_valid) begin
                    n_total++;
                    $display("FAIL bp_first_result_timeout: out_valid stayed 0 for %0d cycles", bp_n);
                end else begin
                    bus8.out_ready = 1'b0;
                    @(negedge clk);
                    chk("bp_in_ready", 32'(bus8.in_ready), 32'd0);
                    repeat (3) @(posedge clk);
                    #1 bus8.out_ready = 1'b1;
                end
            end
            begin
                for (int i = 1; i <= 5; i++)
                    send8(8'(i), 8'h00, 1'b0, 8'(i), 3'd0, {8'(2 * i), 4'b0000});
            end
        join
        drain();

        // Reset with two operations in flight discards both.
        bus8.out_ready = 1'b0;
        send8(8'h01, 8'h00, 1'b0, 8'h01, 3'd0, 12'h020);
        send8(8'h02, 8'h00, 1'b0, 8'h02, 3'd0, 12'h040);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("mid_rst_out", 32'({bus8.out, bus8.flag_z, bus8.flag_n, bus8.flag_c, bus8.flag_v}), 32'd0);
        chk("mid_rst_in_ready", 32'(bus8.in_ready), 32'd1);
        exp8_q.delete();
        bus8.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(bus8.out_valid), 32'd0);
        end
        @(posedge clk); #1;

        // 12-bit directed vectors.
        send12(12'hFFF, 12'h000, 1'b0, 12'h001, 3'd0, 16'h000A);
        send12(12'h801, 12'h000, 1'b0, 12'h00B, 3'd6, 16'h8004);
        send12(12'h000, 12'h801, 1'b1, 12'h00C, 3'd6, 16'h0008);
        send12(12'h801, 12'h000, 1'b0, 12'h00F, 3'd7, 16'h0008);
        send12(12'h801, 12'h000, 1'b0, 12'h00B, 3'd7, 16'h0010);
        send12(12'h800, 12'h000, 1'b0, 12'h001, 3'd1, 16'h7FF1);
        drain();

        // 12-bit random run against the reference model with random consumer stalls.
        rand_phase = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra0 = 12'($urandom); ra1 = 12'($urandom); rb = 12'($urandom);
            rs = 1'($urandom); rop = 3'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                bus12.in_valid = 1'b0; bus12.a0_mux = 12'($urandom); bus12.ctrl = 3'($urandom);
                @(posedge clk); #1;
            end
            send12(ra0, ra1, rs, rb, rop, model12(rs ? ra1 : ra0, rb, rop));
        end
        rand_phase = 1'b0;
        @(posedge clk); #2;
        bus12.out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined successor to the 8-bit conventional ALU. Keeps the same 3-bit opcode map and the two-source A-operand select, with these additions:
- operand width is generic;
- shifts take a variable amount;
- the block produces status flags;
- a valid/ready handshake on both sides lets it sit between a register-file read stage and a writeback stage with backpressure.

## Interface
- WIDTH, 8, operand/result width in bits (≥ 2)
- SHW, $clog2(WIDTH), width of shift-amount field taken from b[SHW-1:0]
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand set present
- in_ready  output  1  block can accept an operand set this cycle
- a0_mux  input  WIDTH  A source 0
- a1_mux  input  WIDTH  A source 1
- a_sel  input  1  0 selects a0_mux, 1 selects a1_mux
- b  input  WIDTH  B operand
- ctrl  input  3  opcode: ADD 000, SUB 001, OR 010, AND 011, XOR 100, NOT 101, LSL 110, LSR 111
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  result
- flag_z  output  1  result == 0
- flag_n  output  1  result[WIDTH-1]
- flag_c  output  1  carry/borrow/shift-out (see Operation)
- flag_v  output  1  signed overflow

## Operation
- Stage 1 (S1) registers the selected A, b and ctrl plus a valid bit on the transfer in_valid && in_ready.
- Stage 2 (S2) computes from the S1 registers and registers out, flags and out_valid.
- Advance rule:
  - s2_adv = !out_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational; no dependency on in_valid)
- S2 loads when s2_adv. It loads s1_valid into out_valid, and loads data/flags only when s1_valid is 1. When s2_adv is 0, all S2 outputs hold.
- Arithmetic is unsigned, modulo 2^WIDTH. Sums use a WIDTH+1-bit internal value.
- ADD:
  - out = a+b
  - c = carry out of bit WIDTH-1
  - v = (a[msb]==b[msb]) && (out[msb]!=a[msb])
- SUB:
  - out = a-b
  - c = borrow, i.e. a < b unsigned
  - v = (a[msb]!=b[msb]) && (out[msb]!=a[msb])
- OR, AND, XOR: bitwise; c = 0, v = 0.
- NOT: out = ~a, b ignored; c = 0, v = 0.
- LSL / LSR: logical shift of a by s = b[SHW-1:0]; zeros fill.
  - c = last bit shifted out: a[WIDTH-s] for LSL, a[s-1] for LSR.
  - s = 0: out = a, c = 0.
  - If WIDTH is not a power of two and s ≥ WIDTH: out = 0, c = 0.
  - v = 0.
- flag_z and flag_n are derived from the result for every opcode.
- With WIDTH=8 and s=1, out matches the legacy ALU bit-for-bit for all opcodes.

## Timing
- Reset (rst_n low, asynchronous): s1_valid=0, out_valid=0, out=0, all flags=0, S1 data registers=0. in_ready reads 1 during and after reset.
- Reset asserted mid-operation discards all in-flight operations; nothing is emitted after release until new input is accepted.
- Latency: an operation accepted at edge k appears with out_valid=1 after edge k+1. An empty pipe always gives 2 cycles from presentation to result.
- Throughput: one operation per cycle while out_ready stays 1.
- Backpressure with out_valid=1 and out_ready=0:
  - out and flags are stable;
  - S1 holds its operation;
  - in_ready = !s1_valid.
  - Two operations are buffered at most.
- A simultaneous S2 drain and S1 load in the same cycle is legal and loses nothing.
- Inputs are sampled only on accepted transfers; values on a0_mux/a1_mux/b/ctrl while in_valid=0 have no effect.

## Test plan
- Reset/idle:
  - Stimulus: assert rst_n=0 mid-stream with two operations in flight.
  - Required: out_valid=0 and out=0 immediately, asynchronously; no stale result appears after release; in_ready=1.
- Arithmetic flags, WIDTH=8:
  - ADD 0x7F+0x01 → out 0x80, n=1, v=1, c=0.
  - ADD 0xFF+0x01 → out 0x00, z=1, c=1, v=0.
  - SUB 0x00-0x01 → out 0xFF, c=1, n=1.
  - SUB 0x80-0x01 → out 0x7F, v=1.
- Shifts, WIDTH=8:
  - LSL 0x81 by 1 → 0x02, c=1.
  - LSR 0x81 by 3 → 0x10, c=0.
  - LSR 0x01 by 1 → 0x00, z=1, c=1.
  - LSL 0xA5 by 0 → 0xA5, c=0.
- Operand select / logic:
  - a0=0x0F, a1=0xF0, b=0x3C: a_sel=0 OR → 0x3F; a_sel=1 AND → 0x30; XOR a_sel=1 → 0xCC; NOT a_sel=0 → 0xF0.
- Backpressure:
  - Stimulus: stream 5 back-to-back ADDs (i+i for i=1..5); hold out_ready=0 for 3 cycles after the first result.
  - Required: in_ready drops once S1 is full; results come out exactly 2,4,6,8,10 in order, with no duplicates and no drops; out stays stable while stalled.
- Width generic:
  - Stimulus: WIDTH=12.
  - Required: ADD 0xFFF+0x001 → 0x000, c=1, z=1; LSL 0x801 by 11 → 0x800, c=0; random compare against a reference model over 1000 operations with random out_ready.
